// File: rtl/multi_phase_signal_ctrl_pkg.sv
// Shared types and helpers for the multi-phase signal controller.
package multi_phase_signal_ctrl_pkg;

  localparam int unsigned ST_W       = 2;
  localparam int unsigned MAX_PHASES = 8;

  // Controller state; the encoding is also the value of the st output.
  typedef enum logic [ST_W-1:0] {
    ST_CLEAR  = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

  // One-hot lamp select for a phase index.
  function automatic logic [MAX_PHASES-1:0] phase_sel(input logic [2:0] p);
    return MAX_PHASES'(1) << p;
  endfunction

endpackage

// File: rtl/multi_phase_signal_ctrl_seg_timer.sv
// Segment countdown: loads max(L,1), counts down on dec, flags expiry at 1.
module multi_phase_signal_ctrl_seg_timer #(
  parameter int unsigned TW      = 16,
  parameter int unsigned RST_VAL = 1
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  input  logic          hold,
  output logic          expire_c
);

  localparam int unsigned RST_EFF = (RST_VAL == 0) ? 1 : RST_VAL;

  logic [TW-1:0] count;

  assign expire_c = (count == TW'(1));

  // Countdown register; a zero load behaves as one.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      count <= TW'(RST_EFF);
    end else if (load) begin
      count <= (load_val == '0) ? TW'(1) : load_val;
    end else if (dec && !hold) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// N-phase green/yellow/all-red sequencer with demand skipping and flash override.
module multi_phase_signal_ctrl
  import multi_phase_signal_ctrl_pkg::*;
#(
  parameter int unsigned N_PHASES   = 2,
  parameter int unsigned TW         = 16,
  parameter int unsigned PW         = 3,
  parameter int unsigned GREEN_DEF  = 100,
  parameter int unsigned YELLOW_DEF = 20,
  parameter int unsigned CLEAR_DEF  = 5,
  parameter int unsigned SKIP_IDLE  = 1,
  parameter int unsigned FLASH_HALF = 50
) (
  input  logic                ck,
  input  logic                rst_n,
  input  logic                en,
  input  logic                flash,
  input  logic                cfg_we,
  input  logic [PW-1:0]       cfg_phase,
  input  logic [TW-1:0]       cfg_green,
  input  logic [TW-1:0]       cfg_yellow,
  input  logic [TW-1:0]       cfg_clear,
  input  logic [N_PHASES-1:0] req,
  output logic [N_PHASES-1:0] g,
  output logic [N_PHASES-1:0] y,
  output logic [N_PHASES-1:0] r,
  output logic [PW-1:0]       phase,
  output logic [ST_W-1:0]     st
);

  state_e              state_q, state_d;
  logic [PW-1:0]       phase_d, tgt;
  logic                first_q, first_d, tog_q, tog_d;
  logic [N_PHASES-1:0] demand_q, demand_d, cur_oh, tgt_oh, nxt_oh;
  logic [N_PHASES-1:0] g_d, y_d, r_d;
  logic [TW-1:0]       green_tab  [N_PHASES];
  logic [TW-1:0]       yellow_tab [N_PHASES];
  logic [TW-1:0]       green_tgt, yellow_cur, t_val;
  logic                t_load, t_hold, t_dec, t_exp;
  logic                f_load, f_dec, f_exp;
  logic                found, enter_green, other_dem;

  assign cur_oh    = N_PHASES'(phase_sel(3'(phase)));
  assign tgt_oh    = N_PHASES'(phase_sel(3'(tgt)));
  assign other_dem = |(demand_q & ~cur_oh);
  assign t_dec     = en && !flash && (state_q != ST_FLASH);
  assign f_dec     = flash && (state_q == ST_FLASH);

  multi_phase_signal_ctrl_seg_timer #(.TW(TW), .RST_VAL(CLEAR_DEF)) u_seg_timer (
    .ck(ck), .rst_n(rst_n), .load(t_load), .load_val(t_val),
    .dec(t_dec), .hold(t_hold), .expire_c(t_exp)
  );

  multi_phase_signal_ctrl_seg_timer #(.TW(TW), .RST_VAL(FLASH_HALF)) u_flash_div (
    .ck(ck), .rst_n(rst_n), .load(f_load), .load_val(TW'(FLASH_HALF)),
    .dec(f_dec), .hold(1'b0), .expire_c(f_exp)
  );

  // Next green phase: round-robin demand search, or plain rotation.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    tgt   = '0;
    if (SKIP_IDLE != 0) begin
      for (int unsigned k = 1; k <= N_PHASES; k++) begin
        idx = (32'(phase) + k) % N_PHASES;
        if (!found && (|(demand_q & N_PHASES'(phase_sel(3'(idx)))))) begin
          found = 1'b1;
          tgt   = PW'(idx);
        end
      end
    end else begin
      found = 1'b1;
      tgt   = first_q ? '0 : PW'((32'(phase) + 1) % N_PHASES);
    end
  end

  // Duration table reads for the segment that may load this cycle.
  always_comb begin
    green_tgt  = '0;
    yellow_cur = '0;
    for (int unsigned i = 0; i < N_PHASES; i++) begin
      if (PW'(i) == tgt)   green_tgt  = green_tab[i];
      if (PW'(i) == phase) yellow_cur = yellow_tab[i];
    end
  end

  // FSM next state, timer control and flash toggle.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase;
    first_d     = first_q;
    tog_d       = tog_q;
    t_load      = 1'b0;
    t_val       = '0;
    t_hold      = 1'b0;
    f_load      = 1'b0;
    enter_green = 1'b0;
    if (flash) begin
      state_d = ST_FLASH;
      if (state_q != ST_FLASH) begin
        tog_d  = 1'b1;
        f_load = 1'b1;
      end else if (f_exp) begin
        tog_d  = ~tog_q;
        f_load = 1'b1;
      end
    end else if (state_q == ST_FLASH) begin
      if (en) begin
        state_d = ST_CLEAR;
        phase_d = '0;
        first_d = 1'b1;
        tog_d   = 1'b0;
        t_load  = 1'b1;
        t_val   = cfg_clear;
      end
    end else if (en && t_exp) begin
      case (state_q)
        ST_CLEAR: begin
          if (found) begin
            state_d     = ST_GREEN;
            phase_d     = tgt;
            first_d     = 1'b0;
            t_load      = 1'b1;
            t_val       = green_tgt;
            enter_green = 1'b1;
          end else begin
            t_hold = 1'b1;
          end
        end
        ST_GREEN: begin
          if ((SKIP_IDLE != 0) && !other_dem) begin
            t_hold = 1'b1;
          end else begin
            state_d = ST_YELLOW;
            t_load  = 1'b1;
            t_val   = yellow_cur;
          end
        end
        ST_YELLOW: begin
          state_d = ST_CLEAR;
          t_load  = 1'b1;
          t_val   = cfg_clear;
        end
        default: ;
      endcase
    end
  end

  // Lamp decode of the next state, so lamps change together with st.
  always_comb begin
    nxt_oh = N_PHASES'(phase_sel(3'(phase_d)));
    g_d    = '0;
    y_d    = '0;
    r_d    = '1;
    case (state_d)
      ST_GREEN:  begin g_d = nxt_oh; r_d = ~nxt_oh; end
      ST_YELLOW: begin y_d = nxt_oh; r_d = ~nxt_oh; end
      ST_FLASH:  r_d = {N_PHASES{tog_d}};
      default: ;
    endcase
    demand_d = (demand_q & ~(enter_green ? tgt_oh : '0)) | req;
  end

  // State, phase, demand and lamp registers.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      phase    <= '0;
      first_q  <= 1'b1;
      tog_q    <= 1'b0;
      demand_q <= '0;
      g        <= '0;
      y        <= '0;
      r        <= '1;
    end else begin
      state_q  <= state_d;
      phase    <= phase_d;
      first_q  <= first_d;
      tog_q    <= tog_d;
      demand_q <= demand_d;
      g        <= g_d;
      y        <= y_d;
      r        <= r_d;
    end
  end

  assign st = state_q;

  // Per-phase duration tables; writes to phases beyond N_PHASES fall through.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_PHASES; i++) begin
        green_tab[i]  <= TW'(GREEN_DEF);
        yellow_tab[i] <= TW'(YELLOW_DEF);
      end
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < N_PHASES; i++) begin
        if (PW'(i) == cfg_phase) begin
          green_tab[i]  <= cfg_green;
          yellow_tab[i] <= cfg_yellow;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// Bench: two controller instances (N=2 fixed rotation, N=4 demand-skipping) against a segment model.
module tb_multi_phase_signal_ctrl;

  logic        ck = 1'b0;
  logic        rst_n, en, flash, cfg_we;
  logic [2:0]  cfg_phase;
  logic [15:0] cfg_green, cfg_yellow, cfg_clear;
  logic [3:0]  req;

  logic [1:0] g_a, y_a, r_a, st_a;
  logic [2:0] phase_a;
  logic [3:0] g_b, y_b, r_b;
  logic [1:0] st_b;
  logic [2:0] phase_b;

  always #5 ck = ~ck;

  multi_phase_signal_ctrl #(
    .N_PHASES(2), .TW(16), .PW(3), .GREEN_DEF(100), .YELLOW_DEF(20),
    .CLEAR_DEF(5), .SKIP_IDLE(0), .FLASH_HALF(50)
  ) u_dut_a (
    .ck(ck), .rst_n(rst_n), .en(en), .flash(flash), .cfg_we(cfg_we),
    .cfg_phase(cfg_phase), .cfg_green(cfg_green), .cfg_yellow(cfg_yellow),
    .cfg_clear(cfg_clear), .req(req[1:0]), .g(g_a), .y(y_a), .r(r_a),
    .phase(phase_a), .st(st_a)
  );

  multi_phase_signal_ctrl #(
    .N_PHASES(4), .TW(16), .PW(3), .GREEN_DEF(12), .YELLOW_DEF(4),
    .CLEAR_DEF(3), .SKIP_IDLE(1), .FLASH_HALF(6)
  ) u_dut_b (
    .ck(ck), .rst_n(rst_n), .en(en), .flash(flash), .cfg_we(cfg_we),
    .cfg_phase(cfg_phase), .cfg_green(cfg_green), .cfg_yellow(cfg_yellow),
    .cfg_clear(cfg_clear), .req(req), .g(g_b), .y(y_b), .r(r_b),
    .phase(phase_b), .st(st_b)
  );

  // Model configuration per instance (0 = A, 1 = B).
  int np    [2] = '{2, 4};
  int skip  [2] = '{0, 1};
  int gdef  [2] = '{100, 12};
  int ydef  [2] = '{20, 4};
  int cdef  [2] = '{5, 3};
  int fhalf [2] = '{50, 6};

  // Model state: segment kind/phase, enabled cycles spent and segment length.
  int       mst [2], mph [2], elapsed [2], seglen [2], first [2], ftog [2], fcnt [2];
  bit [7:0] dem [2];
  int       gt  [2][8];
  int       yt  [2][8];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [1:0] run_val;
  int         run_len;
  int         g0_runs [$];
  int         g1_runs [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int atleast1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mst[u] = 0; mph[u] = 0; elapsed[u] = 0; seglen[u] = atleast1(cdef[u]);
      first[u] = 1; ftog[u] = 0; fcnt[u] = 0; dem[u] = 8'd0;
      for (int p = 0; p < 8; p++) begin
        gt[u][p] = gdef[u];
        yt[u][p] = ydef[u];
      end
    end
  endtask

  // One clock edge of the controller, using the inputs present at that edge.
  task automatic model_step(input int u);
    bit [7:0] pre, mask, nd;
    int       entered, nx;
    bit       fnd;
    mask    = 8'((1 << np[u]) - 1);
    pre     = dem[u];
    entered = -1;
    if (flash) begin
      if (mst[u] != 3) begin
        mst[u] = 3; ftog[u] = 1; fcnt[u] = 0;
      end else begin
        fcnt[u]++;
        if (fcnt[u] >= atleast1(fhalf[u])) begin
          ftog[u] = 1 - ftog[u];
          fcnt[u] = 0;
        end
      end
    end else if (mst[u] == 3) begin
      if (en) begin
        mst[u] = 0; mph[u] = 0; first[u] = 1; ftog[u] = 0;
        elapsed[u] = 0; seglen[u] = atleast1(int'(cfg_clear));
      end
    end else if (en) begin
      if (elapsed[u] + 1 < seglen[u]) begin
        elapsed[u]++;
      end else begin
        case (mst[u])
          0: begin
            fnd = 1'b0; nx = 0;
            if (skip[u] != 0) begin
              for (int k = 1; k <= np[u]; k++) begin
                if (!fnd && (((pre >> ((mph[u] + k) % np[u])) & 8'd1) != 8'd0)) begin
                  fnd = 1'b1;
                  nx  = (mph[u] + k) % np[u];
                end
              end
            end else begin
              fnd = 1'b1;
              nx  = (first[u] != 0) ? 0 : (mph[u] + 1) % np[u];
            end
            if (fnd) begin
              mst[u] = 1; mph[u] = nx; first[u] = 0;
              elapsed[u] = 0; seglen[u] = atleast1(gt[u][nx]); entered = nx;
            end
          end
          1: begin
            if (!((skip[u] != 0) && ((pre & mask & ~(8'd1 << mph[u])) == 8'd0))) begin
              mst[u] = 2; elapsed[u] = 0; seglen[u] = atleast1(yt[u][mph[u]]);
            end
          end
          default: begin
            mst[u] = 0; elapsed[u] = 0; seglen[u] = atleast1(int'(cfg_clear));
          end
        endcase
      end
    end
    nd = pre;
    if (entered >= 0) nd = nd & ~(8'd1 << entered);
    dem[u] = nd | (8'(req) & mask);
    if (cfg_we && (int'(cfg_phase) < np[u])) begin
      gt[u][int'(cfg_phase)] = int'(cfg_green);
      yt[u][int'(cfg_phase)] = int'(cfg_yellow);
    end
  endtask

  // Expected {st, phase, g, y, r} from the model's segment view.
  function automatic logic [16:0] model_out(input int u);
    logic [3:0] gg, yy, rr, all;
    all = 4'((1 << np[u]) - 1);
    gg = 4'd0; yy = 4'd0; rr = all;
    case (mst[u])
      1: begin gg = 4'(1 << mph[u]); rr = all & ~gg; end
      2: begin yy = 4'(1 << mph[u]); rr = all & ~yy; end
      3: rr = (ftog[u] != 0) ? all : 4'd0;
      default: ;
    endcase
    return {2'(mst[u]), 3'(mph[u]), gg, yy, rr};
  endfunction

  task automatic compare_all();
    check($sformatf("A_out cyc%0d", cyc),
          32'({st_a, phase_a, 2'b00, g_a, 2'b00, y_a, 2'b00, r_a}), 32'(model_out(0)));
    check($sformatf("B_out cyc%0d", cyc),
          32'({st_b, phase_b, g_b, y_b, r_b}), 32'(model_out(1)));
  endtask

  task automatic track_runs();
    if (g_a == run_val) begin
      run_len++;
    end else begin
      if (run_val == 2'b01) g0_runs.push_back(run_len);
      if (run_val == 2'b10) g1_runs.push_back(run_len);
      run_val = g_a;
      run_len = 1;
    end
  endtask

  task automatic tick();
    @(posedge ck);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    cyc++;
    compare_all();
    track_runs();
  endtask

  task automatic idle_inputs();
    en = 1'b1; flash = 1'b0; cfg_we = 1'b0; req = 4'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int tr;
    logic [1:0] prev_r;

    rst_n = 1'b0; en = 1'b0; flash = 1'b0; cfg_we = 1'b0; cfg_phase = 3'd0;
    cfg_green = 16'd0; cfg_yellow = 16'd0; cfg_clear = 16'd5; req = 4'd0;
    model_reset();
    run_val = 2'b00; run_len = 0;
    #12;
    compare_all();
    check("rst_r_a", 32'(r_a), 32'h3);
    check("rst_r_b", 32'(r_b), 32'hF);
    #1 rst_n = 1'b1;

    // Directed sequencing, config timing, freeze and demand service.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      cfg_clear = 16'd5;
      if (c == 30)  begin cfg_we = 1'b1; cfg_phase = 3'd1; cfg_green = 16'd3; cfg_yellow = 16'd20; end
      if (c == 31)  begin cfg_we = 1'b1; cfg_phase = 3'd2; cfg_green = 16'd7; cfg_yellow = 16'd2;  end
      if (c == 60)  req = 4'b0100;
      if (c >= 110 && c <= 116) en = 1'b0;
      if (c == 112) req = 4'b1000;
      if (c == 140) begin cfg_we = 1'b1; cfg_phase = 3'd0; cfg_green = 16'd0; cfg_yellow = 16'd20; end
      if (c == 200) req = 4'b0001;
      tick();
      if (c == 100) check("B_rest_g2", 32'({st_b, phase_b}), 32'({2'd1, 3'd2}));
    end
    check("A_g0_first_len",  (g0_runs.size() > 0) ? g0_runs[0] : 0, 100);
    check("A_g1_first_len",  (g1_runs.size() > 0) ? g1_runs[0] : 0, 3);
    check("A_g0_second_len", (g0_runs.size() > 1) ? g0_runs[1] : 0, 1);

    // Randomised traffic, config, freezes and flash windows.
    begin
      int  flash_left;
      bit  flash_prev;
      flash_left = 0;
      flash_prev = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        cfg_we     = ($urandom_range(0, 24) == 0);
        cfg_phase  = 3'($urandom_range(0, 7));
        cfg_green  = 16'($urandom_range(0, 15));
        cfg_yellow = 16'($urandom_range(0, 6));
        cfg_clear  = 16'($urandom_range(0, 6));
        if (flash_left > 0) begin
          flash = 1'b1;
          flash_left--;
        end else begin
          flash = 1'b0;
          if ($urandom_range(0, 299) == 0) flash_left = $urandom_range(10, 120);
        end
        en  = (flash_prev && !flash) ? 1'b1 : ($urandom_range(0, 7) != 0);
        req = flash ? 4'd0 : (($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
        flash_prev = flash;
        tick();
      end
    end
    idle_inputs();
    cfg_clear = 16'd4;
    tick();

    // Flash override mid-green, then exit to phase 0.
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      idle_inputs();
      if (i == 0) begin cfg_we = 1'b1; cfg_phase = 3'd0; cfg_green = 16'd40; cfg_yellow = 16'd3; end
      if (i == 1) begin cfg_we = 1'b1; cfg_phase = 3'd1; cfg_green = 16'd40; cfg_yellow = 16'd3; end
      tick();
      if (mst[0] == 1) ok = 1'b1;
    end
    check("wait_green_a", 32'(ok), 32'd1);
    idle_inputs();
    flash = 1'b1;
    tick();
    check("flash_entry_r", 32'({g_a, y_a, r_a}), 32'h03);
    prev_r = r_a;
    tr = 0;
    for (int i = 0; i < 129; i++) begin
      tick();
      if (r_a != prev_r) tr++;
      prev_r = r_a;
    end
    check("flash_toggles", tr, 2);
    idle_inputs();
    tick();
    check("flash_exit_clear", 32'({st_a, phase_a}), 32'({2'd0, 3'd0}));
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (st_a == 2'd1) ok = 1'b1;
    end
    check("flash_exit_green_seen", 32'(ok), 32'd1);
    check("flash_exit_g0", 32'(phase_a), 32'd0);

    // Asynchronous reset mid-green with non-default tables.
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_green", 32'(st_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_a", 32'({st_a, g_a, y_a, r_a}), 32'({2'd0, 2'b00, 2'b00, 2'b11}));
    check("async_rst_b", 32'({st_b, g_b, y_b, r_b}), 32'({2'd0, 4'h0, 4'h0, 4'hF}));
    @(posedge ck);
    @(posedge ck);
    #1 rst_n = 1'b1;
    #1 compare_all();
    g0_runs.delete();
    g1_runs.delete();
    run_val = g_a;
    run_len = 0;
    for (int i = 0; i < 300; i++) begin
      idle_inputs();
      cfg_clear = 16'd5;
      tick();
      if (i == 50) check("B_demand_cleared", 32'(st_b), 32'd0);
    end
    check("A_g0_after_reset_len", (g0_runs.size() > 0) ? g0_runs[0] : 0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
